stereo_fifo_arbiter: RTL and testbench
======================================

STEREO_FIFO_ARBITER -- requirements
Module: stereo_fifo_arbiter

Interface
REQ-001 SHALL have parameter DROP_CNT_W, default 16, giving the width of the dropped-sample counter.
REQ-002 SHALL have port clk, input, 1 bit: system clock (25 MHz board clock).
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port enable_i, input, 1 bit: accept new samples while high.
REQ-005 SHALL have port l_pcm_i, input, 16 bits: left-channel PCM sample.
REQ-006 SHALL have port l_valid_i, input, 1 bit: single-cycle strobe qualifying l_pcm_i.
REQ-007 SHALL have port r_pcm_i, input, 16 bits: right-channel PCM sample.
REQ-008 SHALL have port r_valid_i, input, 1 bit: single-cycle strobe qualifying r_pcm_i.
REQ-009 SHALL have port fifo_full_i, input, 1 bit: downstream byte FIFO full.
REQ-010 SHALL have port fifo_wr_en_o, output, 1 bit: one-cycle byte write strobe.
REQ-011 SHALL have port fifo_write_data_o, output, 8 bits: byte qualified by fifo_wr_en_o.
REQ-012 SHALL have ports l_pending_o and r_pending_o, outputs, 1 bit each: channel holding register occupied.
REQ-013 SHALL have port drop_cnt_o, output, DROP_CNT_W bits: count of samples lost to overrun.

Function
REQ-014 SHALL keep one holding register and pending flag per channel; on valid with enable_i high and pending clear, capture the sample and set pending the next cycle.
REQ-015 SHALL, on valid while pending is still set (and not cleared that cycle), discard the new sample and increment drop_cnt_o, saturating at all-ones.
REQ-016 SHALL, when pending clears in the same cycle a valid arrives on that channel, accept the new sample (no drop).
REQ-017 SHALL, when both valids arrive in the same cycle, treat each channel independently per REQ-014..016.
REQ-018 SHALL ignore valids while enable_i is low (not captured, not counted); a sample already pending or in flight completes.
REQ-019 SHALL implement FSM IDLE -> [HDR] -> LO -> HI -> IDLE; HDR exists only per Configuration.
REQ-020 SHALL, in IDLE, grant round-robin: if only one channel is pending grant it; if both, grant the channel not granted last; after reset, left has priority.
REQ-021 SHALL, on grant, copy the sample to an output shift register, clear that channel's pending flag, record last_grant, and move to the next state.
REQ-022 SHALL, in LO, if fifo_full_i is low, register fifo_wr_en_o=1 with data=sample[7:0] and go to HI; otherwise wait in LO with fifo_wr_en_o=0.
REQ-023 SHALL, in HI, if fifo_full_i is low, register fifo_wr_en_o=1 with data=sample[15:8] and go to IDLE; otherwise wait.
REQ-024 SHALL assert fifo_wr_en_o for exactly one cycle per byte and never while fifo_full_i is sampled high.
REQ-025 SHALL meet latency: valid in cycle 0, pending high cycle 1, LO cycle 2, low byte strobe cycle 3, high byte strobe cycle 4 (no tag, FIFO not full).
REQ-026 SHALL sustain one sample per 3 cycles (4 with tag) when both channels are continuously pending.

Reset
REQ-027 SHALL, on rst high, asynchronously force state=IDLE, fifo_wr_en_o=0, fifo_write_data_o=0x00, both pending=0, drop_cnt_o=0, last_grant=right.
REQ-028 SHALL abandon any partially written sample on reset mid-sample; no further byte of it is emitted.

Configuration
REQ-029 SHALL support macro CHANNEL_TAG_EN: when defined, HDR state precedes LO and writes tag byte 0xA0 (left) or 0xA1 (right) under the same full-check rule; when undefined, HDR is absent and samples are two bytes.

Verification
REQ-030 Left 0x1234 alone, FIFO not full -> bytes 0x34 (cycle 3), 0x12 (cycle 4); drop_cnt 0.
REQ-031 Simultaneous L=0xAAAA, R=0x5555 after reset -> byte order AA AA 55 55; next simultaneous pair -> left first again (right was last granted).
REQ-032 fifo_full_i high for 10 cycles while in HI -> no strobe during full; high byte written on first cycle after full drops.
REQ-033 Left valid while left pending and FSM stalled by full -> drop_cnt 1, original sample emitted intact.
REQ-034 rst pulse while in HI -> fifo_wr_en_o 0 immediately, no high byte emitted, pendings and drop_cnt 0.
REQ-035 With CHANNEL_TAG_EN, right 0xBEEF -> bytes A1 EF BE on consecutive cycles.

Source files
------------

// File: rtl/stereo_fifo_arbiter.sv
// stereo_fifo_arbiter: holds one PCM sample per channel and serialises them,
// round-robin, into a downstream byte FIFO (low byte first, then high byte).
// Optional macro CHANNEL_TAG_EN prefixes each sample with a tag byte
// (0xA0 left, 0xA1 right); when undefined, samples are two bytes.
module stereo_fifo_arbiter #(
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [15:0]           l_pcm_i,
  input  logic                  l_valid_i,
  input  logic [15:0]           r_pcm_i,
  input  logic                  r_valid_i,
  input  logic                  fifo_full_i,
  output logic                  fifo_wr_en_o,
  output logic [7:0]            fifo_write_data_o,
  output logic                  l_pending_o,
  output logic                  r_pending_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SUM_W    = DROP_CNT_W + 1;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

`ifdef CHANNEL_TAG_EN
  localparam logic [BYTE_W-1:0] TAG_L = 8'hA0;
  localparam logic [BYTE_W-1:0] TAG_R = 8'hA1;
  typedef enum logic [1:0] {IDLE, HDR, LO, HI} state_t;
`else
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
`endif

  state_t              state, state_nxt;
  logic                l_pending, r_pending;
  logic [SAMPLE_W-1:0] l_hold, r_hold;
  logic [SAMPLE_W-1:0] shift, shift_nxt;
  logic                last_right;
  logic                grant_l, grant_r;
  logic                wr_en_nxt;
  logic [BYTE_W-1:0]   data_nxt;
  logic                l_take, r_take, l_drop, r_drop;
  logic [SUM_W-1:0]    drop_sum;

  assign l_pending_o = l_pending;
  assign r_pending_o = r_pending;

  // Capture/drop decisions; a grant in the same cycle frees the slot for the new sample.
  always_comb begin
    l_take   = l_valid_i & enable_i & (~l_pending | grant_l);
    r_take   = r_valid_i & enable_i & (~r_pending | grant_r);
    l_drop   = l_valid_i & enable_i & l_pending & ~grant_l;
    r_drop   = r_valid_i & enable_i & r_pending & ~grant_r;
    drop_sum = {1'b0, drop_cnt_o} + SUM_W'(l_drop) + SUM_W'(r_drop);
  end

  // Next-state, grant and registered-output decode.
  always_comb begin
    state_nxt = state;
    wr_en_nxt = 1'b0;
    data_nxt  = fifo_write_data_o;
    shift_nxt = shift;
    grant_l   = 1'b0;
    grant_r   = 1'b0;
    case (state)
      IDLE: begin
        if (l_pending && (!r_pending || last_right)) grant_l = 1'b1;
        else if (r_pending)                          grant_r = 1'b1;
        if (grant_l || grant_r) begin
          shift_nxt = grant_l ? l_hold : r_hold;
`ifdef CHANNEL_TAG_EN
          state_nxt = HDR;
`else
          state_nxt = LO;
`endif
        end
      end
`ifdef CHANNEL_TAG_EN
      HDR: if (!fifo_full_i) begin
        wr_en_nxt = 1'b1;
        data_nxt  = last_right ? TAG_R : TAG_L;
        state_nxt = LO;
      end
`endif
      LO: if (!fifo_full_i) begin
        wr_en_nxt = 1'b1;
        data_nxt  = shift[BYTE_W-1:0];
        shift_nxt = {BYTE_W'(0), shift[SAMPLE_W-1:BYTE_W]};
        state_nxt = HI;
      end
      HI: if (!fifo_full_i) begin
        wr_en_nxt = 1'b1;
        data_nxt  = shift[BYTE_W-1:0];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, shift register and byte-write outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      shift             <= '0;
      fifo_wr_en_o      <= 1'b0;
      fifo_write_data_o <= '0;
    end else begin
      state             <= state_nxt;
      shift             <= shift_nxt;
      fifo_wr_en_o      <= wr_en_nxt;
      fifo_write_data_o <= data_nxt;
    end
  end

  // Round-robin memory: remembers which channel was granted last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_right <= 1'b1;
    else if (grant_l) last_right <= 1'b0;
    else if (grant_r) last_right <= 1'b1;
  end

  // Per-channel holding registers and pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_pending <= 1'b0;
      r_pending <= 1'b0;
      l_hold    <= '0;
      r_hold    <= '0;
    end else begin
      if (l_take) begin
        l_pending <= 1'b1;
        l_hold    <= l_pcm_i;
      end else if (grant_l) begin
        l_pending <= 1'b0;
      end
      if (r_take) begin
        r_pending <= 1'b1;
        r_hold    <= r_pcm_i;
      end else if (grant_r) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Saturating count of samples lost to overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     drop_cnt_o <= '0;
    else if (drop_sum[SUM_W-1])  drop_cnt_o <= DROP_MAX;
    else                         drop_cnt_o <= drop_sum[DROP_CNT_W-1:0];
  end

endmodule

// File: tb/tb_stereo_fifo_arbiter.sv
// tb_stereo_fifo_arbiter: randomized + directed bench for stereo_fifo_arbiter with
// a queue-based reference model. Honours CHANNEL_TAG_EN when defined.
module tb_stereo_fifo_arbiter;

`ifdef CHANNEL_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif
  localparam int DROP_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] l_pcm, r_pcm;
  logic        l_valid, r_valid;
  logic        fifo_full;
  logic        wr_en;
  logic [7:0]  wdata;
  logic        l_pend, r_pend;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  stereo_fifo_arbiter #(.DROP_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable_i(enable),
    .l_pcm_i(l_pcm), .l_valid_i(l_valid),
    .r_pcm_i(r_pcm), .r_valid_i(r_valid),
    .fifo_full_i(fifo_full),
    .fifo_wr_en_o(wr_en), .fifo_write_data_o(wdata),
    .l_pending_o(l_pend), .r_pending_o(r_pend),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: pending slots plus a queue of bytes still owed for the granted sample.
  logic        m_lp, m_rp, m_last_r;
  logic [15:0] m_lh, m_rh, m_s;
  logic [7:0]  m_bytes[$];
  logic        m_wr;
  logic [7:0]  m_data;
  int          m_drop;
  logic        m_gl, m_gr, m_lt, m_rt, m_ld, m_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lp = 0; m_rp = 0; m_last_r = 1; m_bytes.delete();
      m_wr = 0; m_data = 8'h00; m_drop = 0;
    end else begin
      m_gl = 0; m_gr = 0; m_wr = 0;
      if (m_bytes.size() == 0) begin
        if (m_lp && (!m_rp || m_last_r)) m_gl = 1;
        else if (m_rp)                   m_gr = 1;
        if (m_gl || m_gr) begin
          m_s = m_gl ? m_lh : m_rh;
          if (TAGN == 1) m_bytes.push_back(m_gr ? 8'hA1 : 8'hA0);
          m_bytes.push_back(m_s[7:0]);
          m_bytes.push_back(m_s[15:8]);
          m_last_r = m_gr;
        end
      end else if (!fifo_full) begin
        m_wr   = 1;
        m_data = m_bytes.pop_front();
      end
      m_lt = l_valid && enable && (!m_lp || m_gl);
      m_rt = r_valid && enable && (!m_rp || m_gr);
      m_ld = l_valid && enable && m_lp && !m_gl;
      m_rd = r_valid && enable && m_rp && !m_gr;
      if (m_gl) m_lp = 0;
      if (m_gr) m_rp = 0;
      if (m_lt) begin m_lp = 1; m_lh = l_pcm; end
      if (m_rt) begin m_rp = 1; m_rh = r_pcm; end
      m_drop = m_drop + int'(m_ld) + int'(m_rd);
      if (m_drop > DROP_MAX) m_drop = DROP_MAX;
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_en", 32'(wr_en), 32'(m_wr));
      if (m_wr) chk("wdata", 32'(wdata), 32'(m_data));
      chk("l_pending", 32'(l_pend), 32'(m_lp));
      chk("r_pending", 32'(r_pend), 32'(m_rp));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end

  // Byte log for literal sequence checks.
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  always @(negedge clk) if (!rst && wr_en) got.push_back(wdata);

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic exp_sample(input bit right, input logic [15:0] s);
    if (TAGN == 1) exp_q.push_back(right ? 8'hA1 : 8'hA0);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(s[15:8]);
  endtask

  task automatic check_bytes(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(name, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic send(input bit lv, input bit rv, input logic [15:0] ls, input logic [15:0] rs);
    l_valid = lv; r_valid = rv; l_pcm = ls; r_pcm = rs;
    tick();
    l_valid = 0; r_valid = 0;
  endtask

  task automatic reset_dut();
    rst = 1; l_valid = 0; r_valid = 0; fifo_full = 0; enable = 1;
    l_pcm = 16'h0; r_pcm = 16'h0;
    @(posedge clk); @(posedge clk); #2;
    rst = 0;
    got.delete(); exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    reset_dut();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_data", 32'(wdata), 32'h00);
    chk("rst_l_pending", 32'(l_pend), 32'd0);
    chk("rst_r_pending", 32'(r_pend), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Left 0x1234 alone: fixed latency
    send(1, 0, 16'h1234, 16'h0);
    chk("lat_pending_c1", 32'(l_pend), 32'd1);
    tick();
    chk("lat_no_strobe_c2", 32'(wr_en), 32'd0);
    repeat (TAGN) tick();
    tick();
    chk("lat_lo_strobe", 32'(wr_en), 32'd1);
    chk("lat_lo_byte", 32'(wdata), 32'h34);
    tick();
    chk("lat_hi_strobe", 32'(wr_en), 32'd1);
    chk("lat_hi_byte", 32'(wdata), 32'h12);
    tick();
    chk("lat_done", 32'(wr_en), 32'd0);
    chk("lat_drop", 32'(drop_cnt), 32'd0);

    // Simultaneous pairs: left first after reset and again after right was served
    reset_dut();
    send(1, 1, 16'hAAAA, 16'h5555);
    repeat (10) tick();
    exp_sample(0, 16'hAAAA); exp_sample(1, 16'h5555);
    check_bytes("pair1");
    send(1, 1, 16'hAAAA, 16'h5555);
    repeat (10) tick();
    exp_sample(0, 16'hAAAA); exp_sample(1, 16'h5555);
    check_bytes("pair2");

    // Full stall in HI, with a left accept then a left overrun during the stall
    reset_dut();
    send(1, 0, 16'hCAFE, 16'h0);
    repeat (2 + TAGN) tick();
    chk("stall_lo_strobe", 32'(wr_en), 32'd1);
    fifo_full = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin l_valid = 1; l_pcm = 16'h1111; end
      else if (i == 5) begin l_valid = 1; l_pcm = 16'h2222; end
      else l_valid = 0;
      tick();
      chk("stall_no_strobe", 32'(wr_en), 32'd0);
    end
    l_valid = 0;
    chk("stall_drop", 32'(drop_cnt), 32'd1);
    fifo_full = 0;
    tick();
    chk("stall_hi_strobe", 32'(wr_en), 32'd1);
    chk("stall_hi_byte", 32'(wdata), 32'hCA);
    repeat (8) tick();
    exp_sample(0, 16'hCAFE); exp_sample(0, 16'h1111);
    check_bytes("stall_seq");
    chk("stall_drop_final", 32'(drop_cnt), 32'd1);

    // Reset while in HI abandons the sample and clears everything
    reset_dut();
    l_valid = 1; l_pcm = 16'h1234; tick();
    l_pcm = 16'h5678; tick();
    l_pcm = 16'h9ABC; tick();
    l_valid = 0;
    chk("mid_drop_pre", 32'(drop_cnt), 32'd1);
    repeat (TAGN) tick();
    chk("mid_lo_strobe", 32'(wr_en), 32'd1);
    #1 rst = 1;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_l_pending", 32'(l_pend), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    got.delete();
    @(posedge clk); #2 rst = 0;
    repeat (6) tick();
    chk("mid_no_bytes", 32'(got.size()), 32'd0);

    // Randomized traffic against the model
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 15) != 0);
      fifo_full = ($urandom_range(0, 4) == 0);
      l_valid   = ($urandom_range(0, 2) == 0);
      r_valid   = ($urandom_range(0, 2) == 0);
      l_pcm     = 16'($urandom);
      r_pcm     = 16'($urandom);
      tick();
    end
    l_valid = 0; r_valid = 0; fifo_full = 0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
